// File: rtl/hdmi_tmds_shifter.sv
// TMDS 10:2 shifter for DDR output cells, running entirely in the bit-clock domain.
// Optional clock-lane output and decoder are built when TMDS_CLK_OUT_EN is defined.
module hdmi_tmds_shifter #(
  parameter logic [9:0] BLANK_WORD = 10'b1101010100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tmds_r,
  input  logic [9:0] tmds_g,
  input  logic [9:0] tmds_b,
  input  logic       word_valid,
  output logic       word_ack,
  input  logic       underrun_clr,
  output logic       underrun,
  output logic [1:0] out_r,
  output logic [1:0] out_g,
  output logic [1:0] out_b
`ifdef TMDS_CLK_OUT_EN
  ,
  output logic [1:0] out_clk
`endif
);

  // phase | meaning
  // 0     | bits [1:0] of current word on the lanes
  // 1..3  | bits [3:2] .. [7:6]
  // 4     | bits [9:8]; word_ack, next word loaded at the closing edge
  localparam logic [2:0] PH_0 = 3'd0;
  localparam logic [2:0] PH_1 = 3'd1;
  localparam logic [2:0] PH_2 = 3'd2;
  localparam logic [2:0] PH_3 = 3'd3;
  localparam logic [2:0] PH_4 = 3'd4;

  logic [2:0] phase;
  logic [2:0] phase_nxt;
  logic [9:0] sr_r;
  logic [9:0] sr_g;
  logic [9:0] sr_b;

  // 5..7 are unreachable; any value at or past 4 falls back to 0
  always_comb begin
    phase_nxt = PH_0;
    if (phase < PH_4) phase_nxt = phase + 3'd1;
  end

  assign word_ack = (phase == PH_4);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PH_0;
      sr_r  <= BLANK_WORD;
      sr_g  <= BLANK_WORD;
      sr_b  <= BLANK_WORD;
    end else begin
      phase <= phase_nxt;
      if (word_ack) begin
        sr_r <= word_valid ? tmds_r : BLANK_WORD;
        sr_g <= word_valid ? tmds_g : BLANK_WORD;
        sr_b <= word_valid ? tmds_b : BLANK_WORD;
      end else begin
        sr_r <= {2'b00, sr_r[9:2]};
        sr_g <= {2'b00, sr_g[9:2]};
        sr_b <= {2'b00, sr_b[9:2]};
      end
    end
  end

  // set has priority over a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (word_ack && !word_valid) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  assign out_r = sr_r[1:0];
  assign out_g = sr_g[1:0];
  assign out_b = sr_b[1:0];

`ifdef TMDS_CLK_OUT_EN
  // clock lane 0000011111, LSB first, aligned to the word phase
  always_comb begin
    out_clk = 2'b00;
    case (phase)
      PH_0:    out_clk = 2'b11;
      PH_1:    out_clk = 2'b11;
      PH_2:    out_clk = 2'b01;
      PH_3:    out_clk = 2'b00;
      PH_4:    out_clk = 2'b00;
      default: out_clk = 2'b00;
    endcase
  end
`endif

endmodule

// File: tb/tb_hdmi_tmds_shifter.sv
// Scoreboard bench for hdmi_tmds_shifter: stimulus pushes expected lane pairs and
// per-cycle flags into queues; a monitor pops and compares half a cycle later.
module tb_hdmi_tmds_shifter;

  localparam logic [9:0] BLANK   = 10'b1101010100;
  localparam logic [9:0] CLK_PAT = 10'b0000011111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tmds_r = '0;
  logic [9:0] tmds_g = '0;
  logic [9:0] tmds_b = '0;
  logic       word_valid = 1'b0;
  logic       word_ack;
  logic       underrun_clr = 1'b0;
  logic       underrun;
  logic [1:0] out_r;
  logic [1:0] out_g;
  logic [1:0] out_b;
`ifdef TMDS_CLK_OUT_EN
  logic [1:0] out_clk;
`endif

  hdmi_tmds_shifter dut (
    .clk          (clk),
    .reset        (reset),
    .tmds_r       (tmds_r),
    .tmds_g       (tmds_g),
    .tmds_b       (tmds_b),
    .word_valid   (word_valid),
    .word_ack     (word_ack),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .out_r        (out_r),
    .out_g        (out_g),
    .out_b        (out_b)
`ifdef TMDS_CLK_OUT_EN
    ,
    .out_clk      (out_clk)
`endif
  );

  always #5 clk = ~clk;

  logic [1:0] q_r[$];
  logic [1:0] q_g[$];
  logic [1:0] q_b[$];
  logic [1:0] q_clk[$];
  logic       q_ack[$];
  logic       q_unr[$];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic m_unr = 1'b0;
  logic chk_en = 1'b0;

  task automatic push_word(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    for (int k = 0; k < 5; k++) begin
      q_r.push_back(2'(r >> (2 * k)));
      q_g.push_back(2'(g >> (2 * k)));
      q_b.push_back(2'(b >> (2 * k)));
    end
  endtask

  task automatic model_reset();
    q_r.delete();
    q_g.delete();
    q_b.delete();
    push_word(BLANK, BLANK, BLANK);
    cyc   = 0;
    m_unr = 1'b0;
  endtask

  // One bit-clock cycle: record what this cycle must show, drive inputs sampled at
  // its closing edge, then advance the reference model after the monitor has looked.
  task automatic step(input logic v, input logic [9:0] r, input logic [9:0] g,
                      input logic [9:0] b, input logic clr, input logic rst);
    logic [9:0] cp;
    int p;
    p  = int'(cyc % 5);
    cp = CLK_PAT;
    q_ack.push_back(p == 4);
    q_unr.push_back(m_unr);
    q_clk.push_back({cp[2*p+1], cp[2*p]});
    word_valid   = v;
    tmds_r       = r;
    tmds_g       = g;
    tmds_b       = b;
    underrun_clr = clr;
    reset        = rst;
    #2;
    if (rst) begin
      model_reset();
    end else begin
      if (p == 4) begin
        if (v) push_word(r, g, b);
        else   push_word(BLANK, BLANK, BLANK);
      end
      if (p == 4 && !v) m_unr = 1'b1;
      else if (clr)     m_unr = 1'b0;
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 10'($urandom), 10'($urandom), 10'($urandom), 1'b0, 1'b0);
  endtask

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // monitor
  initial begin
    logic [1:0] e_clk;
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        if (q_r.size() == 0 || q_g.size() == 0 || q_b.size() == 0 ||
            q_ack.size() == 0 || q_unr.size() == 0 || q_clk.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty at %0t: got empty queue expected entry", $time);
        end else begin
          cmp("out_r", out_r, q_r.pop_front());
          cmp("out_g", out_g, q_g.pop_front());
          cmp("out_b", out_b, q_b.pop_front());
          cmp("word_ack", {1'b0, word_ack}, {1'b0, q_ack.pop_front()});
          cmp("underrun", {1'b0, underrun}, {1'b0, q_unr.pop_front()});
          e_clk = q_clk.pop_front();
`ifdef TMDS_CLK_OUT_EN
          cmp("out_clk", out_clk, e_clk);
`endif
        end
      end
    end
  end

  // stimulus
  initial begin
    int gidx;
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    chk_en = 1'b1;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // reset release, then first word loaded at the 5th cycle
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 10'h3FF, 10'h000, 10'h2AA, 1'b0, 1'b0);

    // slot after the load, ack at its end with no valid word
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b0, 10'h155, 10'h155, 10'h155, 1'b0, 1'b0);

    // underrun again with a coincident clear, then a lone clear
    for (int i = 0; i < 4; i++) step(1'b1, 10'h0F0, 10'h0F0, 10'h0F0, 1'b0, 1'b0);
    step(1'b0, 10'h0F0, 10'h0F0, 10'h0F0, 1'b1, 1'b0);
    step(1'b1, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0);
    idle(9);

    // continuous green ramp of 100 words
    gidx = 0;
    while (gidx < 100) begin
      if (cyc % 5 == 4) begin
        step(1'b1, 10'($urandom), 10'(gidx), 10'($urandom), 1'b0, 1'b0);
        gidx++;
      end else begin
        step(1'b1, 10'($urandom), 10'($urandom), 10'($urandom), 1'b0, 1'b0);
      end
    end

    // randomized valid gaps and clears
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 7) != 0), 10'($urandom), 10'($urandom), 10'($urandom),
           ($urandom_range(0, 15) == 0), 1'b0);

    // reset at phase 2 of an all-ones word
    while (cyc % 5 != 4) idle(1);
    step(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
    idle(12);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
